// File: rtl/video_tft_init_sequencer.sv
// Table-driven init sequencer for an 8-bit 8080-style TFT command port (iVCLK domain).
// Define TFT_SEQ_HWRST_EN to add the panel hardware-reset phase before the table walk.
module video_tft_init_sequencer #(
  parameter int pRomAdrsW  = 6,
  parameter int pWrCycles  = 4,
  parameter int pMsDiv     = 60000,
  parameter int pRstLowMs  = 10,
  parameter int pRstWaitMs = 120
) (
  input  logic                 iVCLK,
  input  logic                 inVRST,
  input  logic                 iStart,
  output logic [pRomAdrsW-1:0] oRomAdrs,
  input  logic [9:0]           iRomData,
  output logic [7:0]           oTftData,
  output logic                 oTftRS,
  output logic                 oTftWR,
  output logic                 oTftRD,
  output logic                 oTftCS,
  output logic                 oTftRST,
  output logic                 oTftGate,
  output logic                 oBusy,
  output logic                 oDone
);

`ifdef TFT_SEQ_HWRST_EN
  localparam bit HW_RST_EN = 1'b1;
`else
  localparam bit HW_RST_EN = 1'b0;
`endif

  localparam int PRE_W  = $clog2(pMsDiv + 1);
  localparam int WCNT_W = $clog2(pWrCycles + 1);
  localparam int MS_W   = 16;

  localparam logic [PRE_W-1:0]     PRE_LAST    = PRE_W'(pMsDiv - 1);
  localparam logic [WCNT_W-1:0]    WR_LAST     = WCNT_W'(pWrCycles - 1);
  localparam logic [MS_W-1:0]      RST_LOW_MS  = MS_W'(pRstLowMs);
  localparam logic [MS_W-1:0]      RST_WAIT_MS = MS_W'(pRstWaitMs);
  localparam logic [pRomAdrsW-1:0] ADR_LAST    = {pRomAdrsW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST_LOW  = 4'd1,
    S_RST_WAIT = 4'd2,
    S_FETCH    = 4'd3,
    S_DECODE   = 4'd4,
    S_WR_SETUP = 4'd5,
    S_WR_LOW   = 4'd6,
    S_WR_HIGH  = 4'd7,
    S_DELAY    = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t                 state_q, state_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [MS_W-1:0]        ms_q, ms_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [pRomAdrsW-1:0]   adrs_q, adrs_d;
  logic [7:0]             data_q, data_d;
  logic                   rs_q, rs_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic                   cs_q, cs_d;
  logic                   rst_q, rst_d;
  logic                   gate_q, gate_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   tick_end_s;
  logic                   ms_end_s;
  logic [PRE_W-1:0]       pre_step_s;
  logic [MS_W-1:0]        ms_step_s;
  logic                   wr_end_s;
  logic                   start_s;
  logic                   owns_s;
  state_t                 next_s;

  // A delay of N ms ends on the last prescaler cycle of its final tick; N=0 ends at once.
  assign tick_end_s = (pre_q == PRE_LAST);
  assign ms_end_s   = (ms_q == {MS_W{1'b0}}) || ((ms_q == MS_W'(1)) && tick_end_s);
  assign pre_step_s = tick_end_s ? {PRE_W{1'b0}} : (pre_q + PRE_W'(1));
  assign ms_step_s  = tick_end_s ? (ms_q - MS_W'(1)) : ms_q;
  assign wr_end_s   = (wcnt_q == WR_LAST);
  assign start_s    = ((state_q == S_IDLE) || (state_q == S_DONE)) && iStart;
  assign next_s     = (adrs_q == ADR_LAST) ? S_DONE : S_FETCH;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iVCLK) begin
    if (!inVRST) begin
      state_q <= S_IDLE;
      pre_q   <= {PRE_W{1'b0}};
      ms_q    <= {MS_W{1'b0}};
      wcnt_q  <= {WCNT_W{1'b0}};
      adrs_q  <= {pRomAdrsW{1'b0}};
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      cs_q    <= 1'b1;
      rst_q   <= 1'b1;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      wcnt_q  <= wcnt_d;
      adrs_q  <= adrs_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      rst_q   <= rst_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic together with the prescaler, ms and strobe-width counters.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          state_d = HW_RST_EN ? S_RST_LOW : S_FETCH;
          pre_d   = {PRE_W{1'b0}};
          ms_d    = RST_LOW_MS;
        end else begin
          state_d = state_q;
        end
      end
      S_RST_LOW: begin
        if (ms_end_s) begin
          state_d = S_RST_WAIT;
          pre_d   = {PRE_W{1'b0}};
          ms_d    = RST_WAIT_MS;
        end else begin
          pre_d = pre_step_s;
          ms_d  = ms_step_s;
        end
      end
      S_RST_WAIT: begin
        if (ms_end_s) begin
          state_d = S_FETCH;
        end else begin
          pre_d = pre_step_s;
          ms_d  = ms_step_s;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (iRomData[9:8])
          2'b00, 2'b01: state_d = S_WR_SETUP;
          2'b10: begin
            state_d = S_DELAY;
            pre_d   = {PRE_W{1'b0}};
            ms_d    = {8'h00, iRomData[7:0]};
          end
          default: state_d = S_DONE;
        endcase
      end
      S_WR_SETUP: begin
        state_d = S_WR_LOW;
        wcnt_d  = {WCNT_W{1'b0}};
      end
      S_WR_LOW: begin
        if (wr_end_s) begin
          state_d = S_WR_HIGH;
          wcnt_d  = {WCNT_W{1'b0}};
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_WR_HIGH: begin
        if (wr_end_s) begin
          state_d = next_s;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_DELAY: begin
        if (ms_end_s) begin
          state_d = next_s;
        end else begin
          pre_d = pre_step_s;
          ms_d  = ms_step_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with state_q.
  always_comb begin
    owns_s = (state_d != S_IDLE) && (state_d != S_DONE);
    gate_d = owns_s;
    busy_d = owns_s;
    cs_d   = !owns_s;
    wr_d   = (state_d != S_WR_LOW);
    rd_d   = 1'b1;
    rst_d  = HW_RST_EN ? (state_d != S_RST_LOW) : 1'b1;
    done_d = (state_d == S_DONE);
    if (start_s) begin
      adrs_d = {pRomAdrsW{1'b0}};
    end else if (((state_q == S_WR_HIGH) || (state_q == S_DELAY)) && (state_d == S_FETCH)) begin
      adrs_d = adrs_q + pRomAdrsW'(1);
    end else begin
      adrs_d = adrs_q;
    end
    if ((state_q == S_DECODE) && !iRomData[9]) begin
      data_d = iRomData[7:0];
      rs_d   = iRomData[8];
    end else begin
      data_d = data_q;
      rs_d   = rs_q;
    end
  end

  assign oRomAdrs = adrs_q;
  assign oTftData = data_q;
  assign oTftRS   = rs_q;
  assign oTftWR   = wr_q;
  assign oTftRD   = rd_q;
  assign oTftCS   = cs_q;
  assign oTftRST  = rst_q;
  assign oTftGate = gate_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;

endmodule

// File: tb/tb_video_tft_init_sequencer.sv
// Directed self-checking bench for video_tft_init_sequencer (4-entry table, short timings).
// Builds with or without TFT_SEQ_HWRST_EN; the hardware-reset phase adds 30 busy cycles.
module tb_video_tft_init_sequencer;

  localparam int ADR_W = 2;
`ifdef TFT_SEQ_HWRST_EN
  localparam int HW_CYC = 30;
`else
  localparam int HW_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [ADR_W-1:0] adrs;
  logic [9:0]       rom_q;
  logic [7:0]       tft_data;
  logic             tft_rs, tft_wr, tft_rd, tft_cs, tft_rst, gate, busy, done;
  logic [9:0]       rom [0:3];

  int checks = 0;
  int errors = 0;

  video_tft_init_sequencer #(
    .pRomAdrsW(ADR_W), .pWrCycles(2), .pMsDiv(10), .pRstLowMs(1), .pRstWaitMs(2)
  ) dut (
    .iVCLK(clk), .inVRST(rst_n), .iStart(start), .oRomAdrs(adrs), .iRomData(rom_q),
    .oTftData(tft_data), .oTftRS(tft_rs), .oTftWR(tft_wr), .oTftRD(tft_rd), .oTftCS(tft_cs),
    .oTftRST(tft_rst), .oTftGate(gate), .oBusy(busy), .oDone(done)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM: entry valid one cycle after the address.
  always @(posedge clk) rom_q <= rom[adrs];

  // Bus monitor, sampled on the falling edge.
  int         n_pulse = 0, busy_cnt = 0, rstlo_cnt = 0, rsthi_cnt = 0, rst_fall_cnt = 0;
  int         rd_low_cnt = 0, cs_bad_cnt = 0, unstable_cnt = 0, low_run = 0, high_run = 0;
  int         low_log [0:31];
  int         gap_log [0:31];
  logic [7:0] d_log [0:31];
  logic       rs_log [0:31];
  logic       wr_prev = 1'b1, rst_prev = 1'b1, rs_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    wr_prev   <= tft_wr;
    rst_prev  <= tft_rst;
    data_prev <= tft_data;
    rs_prev   <= tft_rs;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (tft_rst === 1'b0) rstlo_cnt <= rstlo_cnt + 1;
    if (tft_rst === 1'b1 && busy === 1'b1) rsthi_cnt <= rsthi_cnt + 1;
    if (tft_rst === 1'b0 && rst_prev === 1'b1) rst_fall_cnt <= rst_fall_cnt + 1;
    if (tft_rd === 1'b0) rd_low_cnt <= rd_low_cnt + 1;
    if (tft_cs === gate) cs_bad_cnt <= cs_bad_cnt + 1;
    if (tft_wr === 1'b0 && wr_prev === 1'b0 && (tft_data !== data_prev || tft_rs !== rs_prev))
      unstable_cnt <= unstable_cnt + 1;
    if (tft_wr === 1'b0 && wr_prev === 1'b1) begin
      if (n_pulse < 32) begin
        d_log[n_pulse]   <= tft_data;
        rs_log[n_pulse]  <= tft_rs;
        gap_log[n_pulse] <= high_run;
      end
      n_pulse <= n_pulse + 1;
      low_run <= 1;
    end else if (tft_wr === 1'b0) begin
      low_run <= low_run + 1;
    end
    if (tft_wr === 1'b1 && wr_prev === 1'b0) begin
      if (n_pulse > 0 && n_pulse <= 32) low_log[n_pulse-1] <= low_run;
      high_run <= 1;
    end else if (tft_wr === 1'b1) begin
      high_run <= high_run + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_rom(input logic [9:0] e0, input logic [9:0] e1,
                          input logic [9:0] e2, input logic [9:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  int b_pulse, b_busy, b_rstlo, b_rsthi, b_rstfall;

  task automatic snap();
    b_pulse = n_pulse; b_busy = busy_cnt; b_rstlo = rstlo_cnt;
    b_rsthi = rsthi_cnt; b_rstfall = rst_fall_cnt;
  endtask

  // Start a run, optionally re-pulse iStart while busy, then wait for oDone.
  task automatic run_seq(input string tag, input int repulse_at, input int budget);
    int k;
    snap();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (repulse_at > 0) begin
      repeat (repulse_at) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    load_rom(10'h300, 10'h300, 10'h300, 10'h300);
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_adrs", {30'd0, adrs}, 32'd0);
    check_eq("rst_data", {24'd0, tft_data}, 32'd0);
    check_eq("rst_ctl", {24'd0, tft_rs, tft_wr, tft_rd, tft_cs, tft_rst, gate, busy, done},
             32'b0111_1000);
    rst_n = 1'b1;

    // Two byte writes: command 2A then data 55.
    load_rom(10'h02A, 10'h155, 10'h300, 10'h300);
    run_seq("t1", 0, 300);
    check_eq("t1_pulses", n_pulse - b_pulse, 32'd2);
    check_eq("t1_d0", {24'd0, d_log[b_pulse]}, 32'h2A);
    check_eq("t1_rs0", {31'd0, rs_log[b_pulse]}, 32'd0);
    check_eq("t1_d1", {24'd0, d_log[b_pulse+1]}, 32'h55);
    check_eq("t1_rs1", {31'd0, rs_log[b_pulse+1]}, 32'd1);
    check_eq("t1_low0", low_log[b_pulse], 32'd2);
    check_eq("t1_low1", low_log[b_pulse+1], 32'd2);
    check_eq("t1_gap", gap_log[b_pulse+1], 32'd5);
    check_eq("t1_busy", busy_cnt - b_busy, 32'(16 + HW_CYC));
    check_eq("t1_adrs", {30'd0, adrs}, 32'd2);
    check_eq("t1_end_ctl", {28'd0, gate, tft_cs, tft_wr, tft_rst}, 32'b0111);

    // 3 ms delay = 30 cycles; a start pulse mid-delay is ignored.
    load_rom(10'h203, 10'h300, 10'h300, 10'h300);
    run_seq("t2", 10, 300);
    check_eq("t2_busy", busy_cnt - b_busy, 32'(34 + HW_CYC));
    check_eq("t2_pulses", n_pulse - b_pulse, 32'd0);

    // Zero-length delay lasts a single cycle.
    load_rom(10'h200, 10'h300, 10'h300, 10'h300);
    run_seq("t3", 0, 300);
    check_eq("t3_busy", busy_cnt - b_busy, 32'(5 + HW_CYC));

    // End marker only; with the reset phase, iStart during RST_LOW is ignored.
    load_rom(10'h300, 10'h300, 10'h300, 10'h300);
`ifdef TFT_SEQ_HWRST_EN
    run_seq("t4", 3, 300);
    check_eq("t4_rstlo", rstlo_cnt - b_rstlo, 32'd10);
    check_eq("t4_rsthi", rsthi_cnt - b_rsthi, 32'd22);
    check_eq("t4_rstfall", rst_fall_cnt - b_rstfall, 32'd1);
    check_eq("t4_busy", busy_cnt - b_busy, 32'd32);
`else
    run_seq("t4", 0, 300);
    check_eq("t4_rstlo", rstlo_cnt - b_rstlo, 32'd0);
    check_eq("t4_busy", busy_cnt - b_busy, 32'd2);
`endif

    // Full table without end marker: stops after the last entry, no wrap.
    load_rom(10'h011, 10'h011, 10'h011, 10'h011);
    run_seq("t5", 0, 300);
    check_eq("t5_pulses", n_pulse - b_pulse, 32'd4);
    check_eq("t5_busy", busy_cnt - b_busy, 32'(28 + HW_CYC));
    check_eq("t5_adrs", {30'd0, adrs}, 32'd3);
    check_eq("t5_d3", {23'd0, rs_log[b_pulse+3], d_log[b_pulse+3]}, 32'h011);

    // Reset during WR_LOW of entry 1 aborts; restart walks from entry 0.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(tft_wr === 1'b0 && adrs === 2'd1) && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq("t6_found_wrlow", {31'd0, tft_wr}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_eq("t6_abort_ctl", {28'd0, tft_wr, tft_cs, gate, busy}, 32'b1100);
    check_eq("t6_abort_adrs", {30'd0, adrs}, 32'd0);
    rst_n = 1'b1;
    run_seq("t6", 0, 300);
    check_eq("t6_pulses", n_pulse - b_pulse, 32'd4);
    check_eq("t6_busy", busy_cnt - b_busy, 32'(28 + HW_CYC));

    check_eq("rd_never_low", rd_low_cnt, 32'd0);
    check_eq("cs_tracks_gate", cs_bad_cnt, 32'd0);
    check_eq("data_stable", unstable_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
